// File: rtl/bus_pkg.sv
// bus_pkg: shared state type and latency limits for the bus master bridge
//   RD_LATENCY_MAX : largest legal read latency
//   CNT_W          : width of the read-latency down-counter
//   bridge_state_t : bridge FSM states
package bus_pkg;
   localparam int RD_LATENCY_MAX = 15;
   localparam int CNT_W = $clog2(RD_LATENCY_MAX + 1);
   typedef enum logic [1:0] {IDLE, WR, RD, RESP} bridge_state_t;
endpackage

// File: rtl/bus_slave_if.sv
// bus_slave: downstream register bus
//   wr, rd       : one-cycle write / read strobes from the master
//   addr, data_i : address and write data from the master
//   data_o       : read data returned by the slave
//   out          : master-side view, slave : slave-side view
interface bus_slave;
   logic        wr;
   logic        rd;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [31:0] data_o;
   modport out   (output wr, rd, addr, data_i, input data_o);
   modport slave (input wr, rd, addr, data_i, output data_o);
endinterface

// File: rtl/bus_master_bridge.sv
// bus_master_bridge: turns single valid/ready commands into register-bus cycles
//   clk, rst_n                          : clock, asynchronous active-low reset
//   cmd_valid/ready/we/addr/wdata       : command channel, one outstanding at a time
//   rsp_valid/ready/we/rdata            : response channel, rdata is 0 for writes
//   bus                                 : register bus master port
module bus_master_bridge
   import bus_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_we,
   output logic [31:0] rsp_rdata,
   bus_slave.out       bus
);
   localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);
   bridge_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic armed;
   logic accept;
   // armed keeps cmd_ready low until the first edge after reset release
   assign cmd_ready = armed && state == IDLE;
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_valid = state == RESP;
   assign bus.wr    = state == WR;
   // the counter is loaded with LAT on accept, so it still equals LAT only in the first RD cycle
   assign bus.rd    = state == RD && cnt == LAT;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = cmd_we ? WR : RD;
         WR:      state_nxt = RESP;
         RD:      if (cnt == '0) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         armed      <= 1'b0;
         cnt        <= '0;
         bus.addr   <= '0;
         bus.data_i <= '0;
         rsp_we     <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         armed <= 1'b1;
         if (accept) begin
            bus.addr   <= cmd_addr;
            bus.data_i <= cmd_we ? cmd_wdata : '0;
            rsp_we     <= cmd_we;
            rsp_rdata  <= '0;
            cnt        <= LAT;
         end else if (state == RD) begin
            if (cnt == '0) rsp_rdata <= bus.data_o;
            else           cnt <= cnt - CNT_W'(1);
         end
      end
endmodule

// File: tb/tb_bus_master_bridge.sv
// tb_bus_master_bridge: directed checks of bus_master_bridge at RD_LATENCY 2 and 0
module tb_bus_master_bridge;
   import bus_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic        cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_we;
   logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
   logic        cmd0_valid, cmd0_ready, cmd0_we, rsp0_valid, rsp0_ready, rsp0_we;
   logic [31:0] cmd0_addr, cmd0_wdata, rsp0_rdata;
   bus_slave bus ();
   bus_slave bus0 ();
   bus_master_bridge #(.RD_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
      .bus(bus)
   );
   bus_master_bridge #(.RD_LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd0_valid), .cmd_ready(cmd0_ready), .cmd_we(cmd0_we),
      .cmd_addr(cmd0_addr), .cmd_wdata(cmd0_wdata),
      .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready), .rsp_we(rsp0_we), .rsp_rdata(rsp0_rdata),
      .bus(bus0)
   );
   // scoreboard RAM returning read data two cycles after rd
   logic [31:0] mem [0:63];
   logic [31:0] p1 = '0, p2 = '0;
   always @(posedge clk) begin
      if (bus.wr) mem[bus.addr[7:2]] = bus.data_i;
      p1 <= bus.rd ? mem[bus.addr[7:2]] : 32'h0;
      p2 <= p1;
   end
   assign bus.data_o  = p2;
   assign bus0.data_o = bus0.rd ? 32'hA5A5_A5A5 : 32'h0;
   int wr_pulses = 0, rd_pulses = 0;
   bit both_seen = 1'b0;
   always @(posedge clk) begin
      if (bus.wr) wr_pulses++;
      if (bus.rd) rd_pulses++;
   end
   always @(negedge clk)
      if ((bus.wr && bus.rd) || (bus0.wr && bus0.rd)) both_seen = 1'b1;
   int vectors = 0, miscompares = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int w0, r0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[8] = 32'h1234_5678;
      cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
      cmd0_valid = 0; cmd0_we = 0; cmd0_addr = 0; cmd0_wdata = 0; rsp0_ready = 1;
      #2;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_wr", bus.wr, 0);
      check("rst_rd", bus.rd, 0);
      check("rst_addr", bus.addr, 0);
      check("rst_data_i", bus.data_i, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_we", rsp_we, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      tick(); tick();
      rst_n = 1;
      #1 check("ready_before_edge", cmd_ready, 0);
      tick();
      check("ready_after_edge", cmd_ready, 1);
      // zero-latency read on a combinational slave
      cmd0_valid = 1; cmd0_we = 0; cmd0_addr = 32'h50; cmd0_wdata = 32'h1111_1111;
      tick();
      check("l0_rd", bus0.rd, 1);
      check("l0_addr", bus0.addr, 32'h50);
      check("l0_data_i", bus0.data_i, 0);
      check("l0_rsp_early", rsp0_valid, 0);
      check("l0_busy", cmd0_ready, 0);
      cmd0_valid = 0;
      tick();
      check("l0_rsp_valid", rsp0_valid, 1);
      check("l0_rdata", rsp0_rdata, 32'hA5A5_A5A5);
      check("l0_rsp_we", rsp0_we, 0);
      check("l0_rd_drop", bus0.rd, 0);
      tick();
      check("l0_idle", rsp0_valid, 0);
      check("l0_ready", cmd0_ready, 1);
      // single write
      w0 = wr_pulses;
      cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF;
      tick();
      check("wr_strobe", bus.wr, 1);
      check("wr_no_rd", bus.rd, 0);
      check("wr_addr", bus.addr, 32'h10);
      check("wr_data", bus.data_i, 32'hDEAD_BEEF);
      check("wr_rsp_early", rsp_valid, 0);
      check("wr_busy", cmd_ready, 0);
      cmd_valid = 0;
      tick();
      check("wr_strobe_drop", bus.wr, 0);
      check("wr_rsp_valid", rsp_valid, 1);
      check("wr_rsp_we", rsp_we, 1);
      check("wr_rsp_rdata", rsp_rdata, 0);
      tick();
      check("wr_done", rsp_valid, 0);
      check("wr_ready", cmd_ready, 1);
      check("wr_addr_hold", bus.addr, 32'h10);
      check("wr_pulse_count", wr_pulses - w0, 1);
      // latency-2 read
      r0 = rd_pulses;
      cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h20; cmd_wdata = 32'hFFFF_FFFF;
      tick();
      check("rd_strobe", bus.rd, 1);
      check("rd_no_wr", bus.wr, 0);
      check("rd_addr", bus.addr, 32'h20);
      check("rd_data_i_zero", bus.data_i, 0);
      cmd_valid = 0;
      tick();
      check("rd_strobe_drop", bus.rd, 0);
      check("rd_wait1", rsp_valid, 0);
      tick();
      check("rd_wait2", rsp_valid, 0);
      tick();
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rsp_we", rsp_we, 0);
      check("rd_rdata", rsp_rdata, 32'h1234_5678);
      check("rd_pulse_count", rd_pulses - r0, 1);
      tick();
      // back-to-back write then read of the same address
      cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFE_F00D;
      tick();
      check("b2b_wr", bus.wr, 1);
      cmd_we = 0; cmd_wdata = 32'hFFFF_FFFF;
      tick();
      check("b2b_wr_rsp", rsp_valid, 1);
      check("b2b_busy", cmd_ready, 0);
      tick();
      check("b2b_ready", cmd_ready, 1);
      tick();
      check("b2b_rd", bus.rd, 1);
      check("b2b_rd_data_i", bus.data_i, 0);
      cmd_valid = 0;
      tick(); tick(); tick();
      check("b2b_rsp_valid", rsp_valid, 1);
      check("b2b_rdata", rsp_rdata, 32'hCAFE_F00D);
      tick();
      // response back-pressure with a waiting command
      cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h40; cmd_wdata = 32'h0BAD_F00D; rsp_ready = 0;
      tick();
      cmd_we = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_we", rsp_we, 1);
         check("bp_rsp_rdata", rsp_rdata, 0);
         check("bp_busy", cmd_ready, 0);
         check("bp_wr_idle", bus.wr, 0);
         check("bp_rd_idle", bus.rd, 0);
         if (i == 4) rsp_ready = 1;
         tick();
      end
      check("bp_released", rsp_valid, 0);
      check("bp_ready", cmd_ready, 1);
      tick();
      check("bp_next_rd", bus.rd, 1);
      check("bp_next_addr", bus.addr, 32'h40);
      cmd_valid = 0;
      tick(); tick(); tick();
      check("bp_next_rsp", rsp_valid, 1);
      check("bp_next_rdata", rsp_rdata, 32'h0BAD_F00D);
      tick();
      // reset during the rd cycle
      cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h20;
      tick();
      check("ab_rd", bus.rd, 1);
      cmd_valid = 0;
      #1 rst_n = 0;
      #1;
      check("ab_rd_drop", bus.rd, 0);
      check("ab_rsp_valid", rsp_valid, 0);
      check("ab_ready", cmd_ready, 0);
      check("ab_addr", bus.addr, 0);
      tick();
      check("ab_no_rsp", rsp_valid, 0);
      rst_n = 1;
      tick();
      check("ab_ready_after", cmd_ready, 1);
      check("ab_no_rsp_after", rsp_valid, 0);
      cmd_valid = 1;
      tick();
      check("ab_rd_again", bus.rd, 1);
      cmd_valid = 0;
      tick(); tick(); tick();
      check("ab_rsp_valid_again", rsp_valid, 1);
      check("ab_rdata_again", rsp_rdata, 32'h1234_5678);
      tick();
      check("wr_rd_exclusive", both_seen, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
